// File: rtl/serial_add_sub_pkg.sv
// serial_add_sub_pkg: shared state encodings and mode constants for the bit-serial adder/subtractor
package serial_add_sub_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// fa_cell: single combinational full-adder cell
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: W-bit add/subtract processed one bit per clock through one full adder,
// with start/busy/done handshake and registered sum, carry and signed-overflow flags
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   localparam int CW = $clog2(W + 1) < 1 ? 1 : $clog2(W + 1);
   state_t         r_state, w_next;
   logic [W-1:0]   r_opa, r_opb, r_res, r_sum, w_res;
   logic [CW-1:0]  r_cnt;
   logic           r_carry, r_cout, r_ovf, w_s, w_c, w_last, w_accept;
   fa_cell u_fa (
      .a   (r_opa[0]),
      .b   (r_opb[0]),
      .cin (r_carry),
      .s   (w_s),
      .cout(w_c)
   );
   // new bit enters at the MSB so the LSB-first result lands in place after W shifts
   assign w_res    = W'({w_s, r_res} >> 1);
   assign w_last   = r_cnt == CW'(W - 1);
   assign w_accept = start && r_state != RUN;
   always_comb begin
      w_next = r_state;
      if (r_state == RUN) w_next = w_last ? DONE : RUN;
      else if (w_accept) w_next = RUN;
      else if (r_state == DONE) w_next = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_opa   <= '0;
         r_opb   <= '0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_opa   <= a;
            r_opb   <= (sub == MODE_SUB) ? ~b : b;
            r_carry <= sub == MODE_SUB;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_res   <= w_res;
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
               r_sum  <= w_res;
               r_cout <= w_c;
               r_ovf  <= r_carry ^ w_c;
            end
         end
      end
   end
   assign busy = r_state == RUN;
   assign done = r_state == DONE;
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of the bit-serial adder/subtractor at W=8 and W=1
module tb_serial_add_sub;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       start = 1'b0, sub = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;
   logic       start1 = 1'b0, sub1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0, sum1;
   logic       busy1, done1, cout1, ovf1;
   int         tests = 0, fails = 0;

   always #5 clk = ~clk;

   serial_add_sub #(.W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );
   serial_add_sub #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   // present an operation at a negedge, let E0 pass, return at the following negedge
   task automatic go(input logic s, input logic [7:0] x, input logic [7:0] y);
      @(negedge clk);
      start = 1'b1; sub = s; a = x; b = y;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // n counts rising edges since E0 inclusive at the negedge where done is seen
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      tests++;
      if ({busy, done, sum, cout, ovf} !== 11'd0) begin
         fails++;
         $display("FAIL reset got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0", busy, done, sum, cout, ovf);
      end
      tests++;
      if ({busy1, done1, sum1, cout1, ovf1} !== 5'd0) begin
         fails++;
         $display("FAIL reset_w1 got busy=%b done=%b sum=%b cout=%b ovf=%b exp all 0", busy1, done1, sum1, cout1, ovf1);
      end
   endtask

   task automatic test_add_sub;
      logic       vs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] va[4]  = '{8'h5A, 8'hFF, 8'h10, 8'h80};
      logic [7:0] vb[4]  = '{8'h3C, 8'h01, 8'h20, 8'h01};
      logic [7:0] es[4]  = '{8'h96, 8'h00, 8'hF0, 8'h7F};
      logic       ec[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic       eo[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      int n;
      for (int i = 0; i < 4; i++) begin
         go(vs[i], va[i], vb[i]);
         tests++;
         if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_run[%0d] got %b exp 1", i, busy);
         end
         wait_done(n);
         tests++;
         if (n !== 9) begin
            fails++;
            $display("FAIL latency[%0d] got %0d exp 9", i, n);
         end
         tests++;
         if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
            fails++;
            $display("FAIL result[%0d] got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b", i, sum, cout, ovf, es[i], ec[i], eo[i]);
         end
         @(negedge clk);
         tests++;
         if ({done, busy} !== 2'b00) begin
            fails++;
            $display("FAIL done_pulse[%0d] got done=%b busy=%b exp 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_ignore_start;
      int n;
      go(1'b0, 8'h12, 8'h34);
      n = 1;
      repeat (2) begin @(negedge clk); n++; end
      start = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
      @(negedge clk); n++;
      start = 1'b0;
      @(negedge clk); n++;
      start = 1'b1; a = 8'h00; b = 8'h77;
      @(negedge clk); n++;
      start = 1'b0;
      while (!done && n < 30) begin @(negedge clk); n++; end
      tests++;
      if (n !== 9) begin
         fails++;
         $display("FAIL ignore_latency got %0d exp 9", n);
      end
      tests++;
      if ({sum, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL ignore_result got sum=%h cout=%b ovf=%b exp sum=46 cout=0 ovf=0", sum, cout, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n;
      go(1'b0, 8'h70, 8'h20);
      wait_done(n);
      tests++;
      if ({sum, cout, ovf} !== {8'h90, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL b2b_first got sum=%h cout=%b ovf=%b exp sum=90 cout=0 ovf=1", sum, cout, ovf);
      end
      start = 1'b1; sub = 1'b1; a = 8'h05; b = 8'h09;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({done, busy, sum} !== {2'b01, 8'h90}) begin
         fails++;
         $display("FAIL b2b_accept got done=%b busy=%b sum=%h exp done=0 busy=1 sum=90", done, busy, sum);
      end
      wait_done(n);
      tests++;
      if (n !== 9) begin
         fails++;
         $display("FAIL b2b_latency got %0d exp 9", n);
      end
      tests++;
      if ({sum, cout, ovf} !== {8'hFC, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL b2b_second got sum=%h cout=%b ovf=%b exp sum=fc cout=0 ovf=0", sum, cout, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_run;
      int n;
      logic seen;
      go(1'b0, 8'h01, 8'h02);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, sum, cout, ovf} !== 11'd0) begin
         fails++;
         $display("FAIL reset_async got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0", busy, done, sum, cout, ovf);
      end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | done;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         seen = seen | done | busy;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++;
         $display("FAIL reset_nodone got activity=%b exp 0", seen);
      end
      go(1'b1, 8'h03, 8'h05);
      wait_done(n);
      tests++;
      if ({n[4:0], sum, cout, ovf} !== {5'd9, 8'hFE, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_after got n=%0d sum=%h cout=%b ovf=%b exp n=9 sum=fe cout=0 ovf=0", n, sum, cout, ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_w1;
      logic       vs[3] = '{1'b0, 1'b0, 1'b1};
      logic       va[3] = '{1'b1, 1'b1, 1'b0};
      logic       vb[3] = '{1'b1, 1'b0, 1'b1};
      logic [2:0] ex[3] = '{3'b010, 3'b100, 3'b101};
      logic [2:0] got;
      int n;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start1 = 1'b1; sub1 = vs[i]; a1 = va[i]; b1 = vb[i];
         @(posedge clk);
         @(negedge clk);
         start1 = 1'b0;
         n = 1;
         while (!done1 && n < 10) begin @(negedge clk); n++; end
         tests++;
         if (n !== 2) begin
            fails++;
            $display("FAIL w1_latency[%0d] got %0d exp 2", i, n);
         end
         got = {sum1, cout1, ovf1};
         // 1+1 has only sum and carry compared
         if (i == 0) begin
            got[0] = 1'b0;
         end
         tests++;
         if (got !== ex[i]) begin
            fails++;
            $display("FAIL w1_result[%0d] got sum/cout/ovf=%b exp %b", i, got, ex[i]);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      #12;
      test_reset;
      @(negedge clk);
      rst_n = 1'b1;
      test_add_sub;
      test_ignore_start;
      test_back_to_back;
      test_reset_run;
      test_w1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
